// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared constants for the multi-cycle controller.
//   - FSM state encoding (3-bit, debug-visible on W_state)
//   - opcode / R-type funct constants
//   - ALU, shift, branch and jump select codes
//   - ctrl_t: the control bundle produced by ctrl_decode
package ctrl_pkg;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_TRAP   = 3'd5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_NOR  = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b110;
  localparam logic [2:0] ALU_SLTU = 3'b111;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_SLL  = 2'b01;
  localparam logic [1:0] SH_SRL  = 2'b10;
  localparam logic [1:0] SH_SRA  = 2'b11;

  localparam logic [1:0] BR_EQ = 2'b01;
  localparam logic [1:0] BR_NE = 2'b10;
  localparam logic [1:0] JB_J  = 2'b01;
  localparam logic [1:0] JB_JR = 2'b10;

  // Where an instruction goes after EXEC.
  typedef enum logic [1:0] {
    CLS_JUMP = 2'd0,  // finishes in EXEC (branches, jumps, NOP)
    CLS_MEM  = 2'd1,  // lw / sw
    CLS_WB   = 2'd2   // register write-back (ALU, shifts, jal)
  } cls_t;

  typedef struct packed {
    logic [2:0] alu_sel;
    logic       wb_regsrc_sel;
    logic       ex_rt_sel;
    logic       write_src_sel;
    logic [1:0] branch;
    logic [1:0] j_branch;
    logic       imme_sign_extend;
    logic [1:0] shift;
    logic       is_jal;
    logic       is_sw;
    cls_t       cls;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational instruction decode.
// Ports:
//   i_op, i_funct  latched opcode / funct from the controller
//   o_ctrl         control bundle (datapath selects + routing class)
//   o_illegal      1 when op/funct is not a recognised instruction
// Unrecognised encodings return CTRL_NOP, which routes as CLS_JUMP.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output ctrl_t      o_ctrl,
  output logic       o_illegal
);

  always_comb begin
    o_ctrl    = CTRL_NOP;
    o_illegal = 1'b0;
    case (i_op)
      OP_RTYPE: begin
        o_ctrl.write_src_sel = 1'b1;
        o_ctrl.cls           = CLS_WB;
        case (i_funct)
          FN_ADD, FN_ADDU: o_ctrl.alu_sel = ALU_ADD;
          FN_SUB, FN_SUBU: o_ctrl.alu_sel = ALU_SUB;
          FN_AND:          o_ctrl.alu_sel = ALU_AND;
          FN_OR:           o_ctrl.alu_sel = ALU_OR;
          FN_XOR:          o_ctrl.alu_sel = ALU_XOR;
          FN_NOR:          o_ctrl.alu_sel = ALU_NOR;
          FN_SLT:          o_ctrl.alu_sel = ALU_SLT;
          FN_SLTU:         o_ctrl.alu_sel = ALU_SLTU;
          FN_SLL:          o_ctrl.shift   = SH_SLL;
          FN_SRL:          o_ctrl.shift   = SH_SRL;
          FN_SRA:          o_ctrl.shift   = SH_SRA;
          FN_JR: begin
            o_ctrl.j_branch = JB_JR;
            o_ctrl.cls      = CLS_JUMP;
          end
          default: begin
            o_ctrl    = CTRL_NOP;
            o_illegal = 1'b1;
          end
        endcase
      end
      // Immediate ALU ops take the immediate as the second operand.
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
        o_ctrl.ex_rt_sel        = 1'b1;
        o_ctrl.cls              = CLS_WB;
        o_ctrl.imme_sign_extend = (i_op == OP_ADDI) || (i_op == OP_ADDIU) || (i_op == OP_SLTI);
        case (i_op)
          OP_SLTI: o_ctrl.alu_sel = ALU_SLT;
          OP_ANDI: o_ctrl.alu_sel = ALU_AND;
          OP_ORI:  o_ctrl.alu_sel = ALU_OR;
          OP_XORI: o_ctrl.alu_sel = ALU_XOR;
          default: o_ctrl.alu_sel = ALU_ADD;
        endcase
      end
      OP_LW, OP_SW: begin
        o_ctrl.alu_sel          = ALU_ADD;
        o_ctrl.imme_sign_extend = 1'b1;
        o_ctrl.ex_rt_sel        = 1'b1;
        o_ctrl.wb_regsrc_sel    = (i_op == OP_LW);
        o_ctrl.is_sw            = (i_op == OP_SW);
        o_ctrl.cls              = CLS_MEM;
      end
      // Branch offsets are signed; compare via subtraction.
      OP_BEQ, OP_BNE: begin
        o_ctrl.alu_sel          = ALU_SUB;
        o_ctrl.imme_sign_extend = 1'b1;
        o_ctrl.branch           = (i_op == OP_BEQ) ? BR_EQ : BR_NE;
        o_ctrl.cls              = CLS_JUMP;
      end
      OP_J: begin
        o_ctrl.j_branch = JB_J;
        o_ctrl.cls      = CLS_JUMP;
      end
      OP_JAL: begin
        o_ctrl.j_branch = JB_J;
        o_ctrl.is_jal   = 1'b1;
        o_ctrl.cls      = CLS_WB;
      end
      default: begin
        o_ctrl    = CTRL_NOP;
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: FETCH/DECODE/EXEC/MEM/WB controller for a multi-cycle
// MIPS-style datapath.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   W_instr_op/W_instr_funct opcode/funct from datapath (latched in DECODE)
//   W_mem_ready              memory access completes this cycle
//   W_regfile_wea..W_jal_en  datapath control (zero in FETCH/DECODE)
//   W_pc_wea, W_ir_wea       PC / IR load enables
//   W_illegal                trap flag
//   W_state                  current FSM state (debug)
// Build option: define MULTI_CYCLE_CTRL_TRAP_EN to trap illegal instructions
// in a terminal TRAP state; otherwise they retire as a NOP.
module multi_cycle_ctrl
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] W_instr_op,
  input  logic [5:0] W_instr_funct,
  input  logic       W_mem_ready,
  output logic       W_regfile_wea,
  output logic [2:0] W_alu_sel,
  output logic [3:0] W_mem_wea,
  output logic       W_wb_regsrc_sel,
  output logic       W_ex_rt_sel,
  output logic       W_write_src_sel,
  output logic [1:0] W_branch,
  output logic [1:0] W_j_branch,
  output logic       W_imme_sign_extend,
  output logic [1:0] W_shift,
  output logic       W_jal_en,
  output logic       W_pc_wea,
  output logic       W_ir_wea,
  output logic       W_illegal,
  output logic [2:0] W_state
);

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic [5:0] r_op;
  logic [5:0] r_funct;
  ctrl_t      w_ctrl;
  logic       w_illegal;
  logic       w_fields_en;
  logic       w_exec_retire;
  logic       w_sw_done;

  ctrl_decode u_decode (
    .i_op      (r_op),
    .i_funct   (r_funct),
    .o_ctrl    (w_ctrl),
    .o_illegal (w_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_FETCH;
      r_op    <= '0;
      r_funct <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DECODE) begin
        r_op    <= W_instr_op;
        r_funct <= W_instr_funct;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_FETCH:  if (W_mem_ready) w_next = ST_DECODE;
      ST_DECODE: w_next = ST_EXEC;
      ST_EXEC: begin
        case (w_ctrl.cls)
          CLS_MEM: w_next = ST_MEM;
          CLS_WB:  w_next = ST_WB;
          default: w_next = ST_FETCH;
        endcase
`ifdef MULTI_CYCLE_CTRL_TRAP_EN
        if (w_illegal) w_next = ST_TRAP;
`else
        if (w_illegal) w_next = ST_FETCH;
`endif
      end
      ST_MEM:    if (W_mem_ready) w_next = w_ctrl.is_sw ? ST_FETCH : ST_WB;
      ST_WB:     w_next = ST_FETCH;
      ST_TRAP:   w_next = ST_TRAP;
      default:   w_next = ST_FETCH;
    endcase
  end

  // rst gates every output so they drop in the same cycle reset rises,
  // even while FETCH sees W_mem_ready high.
  assign w_fields_en = ~rst & ((r_state == ST_EXEC) || (r_state == ST_MEM) || (r_state == ST_WB));
  assign w_sw_done   = ~rst & (r_state == ST_MEM) & W_mem_ready & w_ctrl.is_sw;

`ifdef MULTI_CYCLE_CTRL_TRAP_EN
  assign w_exec_retire = (r_state == ST_EXEC) & (w_ctrl.cls == CLS_JUMP) & ~w_illegal;
  assign W_illegal     = ~rst & (r_state == ST_TRAP);
`else
  // Illegal encodings decode as CLS_JUMP, so they retire here as a NOP.
  assign w_exec_retire = (r_state == ST_EXEC) & (w_ctrl.cls == CLS_JUMP);
  assign W_illegal     = 1'b0;
`endif

  assign W_pc_wea      = ~rst & (w_exec_retire | (r_state == ST_WB)) | w_sw_done;
  assign W_ir_wea      = ~rst & (r_state == ST_FETCH) & W_mem_ready;
  assign W_regfile_wea = ~rst & (r_state == ST_WB);
  assign W_mem_wea     = {4{w_sw_done}};
  assign W_jal_en      = ~rst & (r_state == ST_WB) & w_ctrl.is_jal;

  assign W_alu_sel          = w_fields_en ? w_ctrl.alu_sel          : 3'b000;
  assign W_wb_regsrc_sel    = w_fields_en ? w_ctrl.wb_regsrc_sel    : 1'b0;
  assign W_ex_rt_sel        = w_fields_en ? w_ctrl.ex_rt_sel        : 1'b0;
  assign W_write_src_sel    = w_fields_en ? w_ctrl.write_src_sel    : 1'b0;
  assign W_branch           = w_fields_en ? w_ctrl.branch           : 2'b00;
  assign W_j_branch         = w_fields_en ? w_ctrl.j_branch         : 2'b00;
  assign W_imme_sign_extend = w_fields_en ? w_ctrl.imme_sign_extend : 1'b0;
  assign W_shift            = w_fields_en ? w_ctrl.shift            : 2'b00;

  assign W_state = r_state;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
`timescale 1ns/1ps
module tb_multi_cycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = '0;
  logic [5:0] fn = '0;
  logic       mem_ready = 1'b0;

  logic       W_regfile_wea, W_wb_regsrc_sel, W_ex_rt_sel, W_write_src_sel;
  logic       W_imme_sign_extend, W_jal_en, W_pc_wea, W_ir_wea, W_illegal;
  logic [2:0] W_alu_sel, W_state;
  logic [3:0] W_mem_wea;
  logic [1:0] W_branch, W_j_branch, W_shift;

  always #5 clk = ~clk;

  multi_cycle_ctrl dut (
    .clk(clk), .rst(rst), .W_instr_op(op), .W_instr_funct(fn), .W_mem_ready(mem_ready),
    .W_regfile_wea(W_regfile_wea), .W_alu_sel(W_alu_sel), .W_mem_wea(W_mem_wea),
    .W_wb_regsrc_sel(W_wb_regsrc_sel), .W_ex_rt_sel(W_ex_rt_sel),
    .W_write_src_sel(W_write_src_sel), .W_branch(W_branch), .W_j_branch(W_j_branch),
    .W_imme_sign_extend(W_imme_sign_extend), .W_shift(W_shift), .W_jal_en(W_jal_en),
    .W_pc_wea(W_pc_wea), .W_ir_wea(W_ir_wea), .W_illegal(W_illegal), .W_state(W_state)
  );

  int total = 0;
  int bad   = 0;

  // Instruction classes: 0 retires in EXEC, 1 load, 2 store, 3 ALU write-back, 4 jal.
  typedef struct {
    string      name;
    logic [5:0] op, fn;
    logic [2:0] alu;
    logic       wbsrc, exrt, wsrc;
    logic [1:0] br, jb;
    logic       sext;
    logic [1:0] sh;
    int         cls;
  } ent_t;

  typedef struct {
    string name;
    int    fields, nreg, nmem, njal, nir, end_state, mem_cycles, cls;
  } exp_t;

  ent_t tbl[$];
  exp_t sbq[$];

  // ready modes: 0 random, 2 high, 3 low for the first low_lim MEM cycles
  int mode = 2;
  int low_lim = 0;
  int lowcnt = 0;

  function automatic void add(string nm, logic [5:0] o, logic [5:0] f, logic [2:0] a,
                              logic wb, logic er, logic ws, logic [1:0] b, logic [1:0] j,
                              logic se, logic [1:0] s, int c);
    ent_t t;
    t.name = nm; t.op = o; t.fn = f; t.alu = a; t.wbsrc = wb; t.exrt = er; t.wsrc = ws;
    t.br = b; t.jb = j; t.sext = se; t.sh = s; t.cls = c;
    tbl.push_back(t);
  endfunction

  function automatic int find(string nm);
    foreach (tbl[i]) if (tbl[i].name == nm) return i;
    return 0;
  endfunction

  function automatic bit legal(logic [5:0] o, logic [5:0] f);
    foreach (tbl[i]) if (tbl[i].op == o && (o != 6'd0 || tbl[i].fn == f)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic exp_t mk_exp(ent_t t, int memcyc);
    exp_t e;
    e.name = t.name;
    e.fields = int'({t.alu, t.wbsrc, t.exrt, t.wsrc, t.br, t.jb, t.sext, t.sh});
    e.nreg = (t.cls == 1 || t.cls == 3 || t.cls == 4) ? 1 : 0;
    e.nmem = (t.cls == 2) ? 1 : 0;
    e.njal = (t.cls == 4) ? 1 : 0;
    e.nir = 1;
    e.end_state = (t.cls == 0) ? 2 : (t.cls == 2) ? 3 : 4;
    e.mem_cycles = memcyc;
    e.cls = t.cls;
    return e;
  endfunction

  function automatic int act_fields();
    return int'({W_alu_sel, W_wb_regsrc_sel, W_ex_rt_sel, W_write_src_sel, W_branch,
                 W_j_branch, W_imme_sign_extend, W_shift});
  endfunction

  function automatic int all_outs();
    return int'({W_regfile_wea, W_alu_sel, W_mem_wea, W_wb_regsrc_sel, W_ex_rt_sel,
                 W_write_src_sel, W_branch, W_j_branch, W_imme_sign_extend, W_shift,
                 W_jal_en, W_pc_wea, W_ir_wea, W_illegal, W_state});
  endfunction

  task automatic cmp(string nm, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    case (mode)
      0: mem_ready = ($urandom_range(0, 2) != 0);
      3: begin
        if (W_state == 3'd3) begin
          if (lowcnt < low_lim) begin mem_ready = 1'b0; lowcnt++; end
          else mem_ready = 1'b1;
        end else begin
          lowcnt = 0;
          mem_ready = 1'b1;
        end
      end
      default: mem_ready = 1'b1;
    endcase
  end

  // Monitor: per-cycle rules plus a scoreboard pop on every PC load.
  int acc_reg, acc_mem, acc_jal, acc_ir, acc_memcyc;
  bit prev_mem_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    bit ok;
    if (rst) begin
      acc_reg = 0; acc_mem = 0; acc_jal = 0; acc_ir = 0; acc_memcyc = 0;
      prev_mem_done = 1'b0;
    end else begin
      ok = 1'b1;
      if (W_state <= 3'd1 && (act_fields() != 0 || W_pc_wea || W_regfile_wea ||
          W_mem_wea != 0 || W_jal_en)) ok = 1'b0;
      if (W_regfile_wea && W_state != 3'd4) ok = 1'b0;
      if (W_jal_en && W_state != 3'd4) ok = 1'b0;
      if (W_mem_wea != 4'h0 && !(W_state == 3'd3 && mem_ready && W_mem_wea == 4'hF)) ok = 1'b0;
      if (W_ir_wea != (W_state == 3'd0 && mem_ready)) ok = 1'b0;
`ifdef MULTI_CYCLE_CTRL_TRAP_EN
      if (W_illegal != (W_state == 3'd5)) ok = 1'b0;
      if (W_state == 3'd5 && (W_pc_wea || W_regfile_wea || W_mem_wea != 0)) ok = 1'b0;
`else
      if (W_illegal) ok = 1'b0;
`endif
      cmp("cycle_rules", int'(ok), 1);
      if (prev_mem_done && sbq.size() > 0 && sbq[0].cls == 1)
        cmp({sbq[0].name, "_wb_after_ready"}, int'(W_regfile_wea), 1);
      prev_mem_done = (W_state == 3'd3) && mem_ready;
      if (W_ir_wea) acc_ir++;
      if (W_regfile_wea) acc_reg++;
      if (W_mem_wea == 4'hF) acc_mem++;
      if (W_jal_en) acc_jal++;
      if (W_state == 3'd3) acc_memcyc++;
      if (W_pc_wea) begin
        if (sbq.size() == 0) begin
          cmp("unexpected_pc_wea", 1, 0);
        end else begin
          e = sbq.pop_front();
          cmp({e.name, "_fields"}, act_fields(), e.fields);
          cmp({e.name, "_end_state"}, int'(W_state), e.end_state);
          cmp({e.name, "_regfile_writes"}, acc_reg, e.nreg);
          cmp({e.name, "_mem_writes"}, acc_mem, e.nmem);
          cmp({e.name, "_jal_en"}, acc_jal, e.njal);
          cmp({e.name, "_ir_loads"}, acc_ir, e.nir);
          if (e.mem_cycles >= 0) cmp({e.name, "_mem_cycles"}, acc_memcyc, e.mem_cycles);
        end
        acc_reg = 0; acc_mem = 0; acc_jal = 0; acc_ir = 0; acc_memcyc = 0;
      end
    end
  end

  task automatic drive(ent_t t);
    op = t.op;
    fn = (t.op == 6'd0) ? t.fn : 6'($urandom);
  endtask

  // Runs the current instruction to FETCH; the inputs are scrambled once
  // EXEC is reached so only the latched copy can steer the rest.
  task automatic run_to_fetch(string nm);
    int n = 0;
    while (W_state != 3'd2 && n < 300) begin step(); n++; end
    if (W_state != 3'd2) cmp({nm, "_timeout_exec"}, int'(W_state), 2);
    op = 6'($urandom); fn = 6'($urandom);
    n = 0;
    while (W_state != 3'd0 && n < 300) begin step(); n++; end
    if (W_state != 3'd0) cmp({nm, "_timeout_fetch"}, int'(W_state), 0);
  endtask

  task automatic issue(ent_t t, int memcyc);
    sbq.push_back(mk_exp(t, memcyc));
    drive(t);
    run_to_fetch(t.name);
  endtask

  initial begin
    ent_t t;
    ent_t ill;
    int n;
    add("add",  6'o00, 6'b100000, 3'b000, 0, 0, 1, 2'b00, 2'b00, 0, 2'b00, 3);
    add("addu", 6'o00, 6'b100001, 3'b000, 0, 0, 1, 2'b00, 2'b00, 0, 2'b00, 3);
    add("sub",  6'o00, 6'b100010, 3'b001, 0, 0, 1, 2'b00, 2'b00, 0, 2'b00, 3);
    add("subu", 6'o00, 6'b100011, 3'b001, 0, 0, 1, 2'b00, 2'b00, 0, 2'b00, 3);
    add("and",  6'o00, 6'b100100, 3'b010, 0, 0, 1, 2'b00, 2'b00, 0, 2'b00, 3);
    add("or",   6'o00, 6'b100101, 3'b011, 0, 0, 1, 2'b00, 2'b00, 0, 2'b00, 3);
    add("xor",  6'o00, 6'b100110, 3'b100, 0, 0, 1, 2'b00, 2'b00, 0, 2'b00, 3);
    add("nor",  6'o00, 6'b100111, 3'b101, 0, 0, 1, 2'b00, 2'b00, 0, 2'b00, 3);
    add("slt",  6'o00, 6'b101010, 3'b110, 0, 0, 1, 2'b00, 2'b00, 0, 2'b00, 3);
    add("sltu", 6'o00, 6'b101011, 3'b111, 0, 0, 1, 2'b00, 2'b00, 0, 2'b00, 3);
    add("sll",  6'o00, 6'b000000, 3'b000, 0, 0, 1, 2'b00, 2'b00, 0, 2'b01, 3);
    add("srl",  6'o00, 6'b000010, 3'b000, 0, 0, 1, 2'b00, 2'b00, 0, 2'b10, 3);
    add("sra",  6'o00, 6'b000011, 3'b000, 0, 0, 1, 2'b00, 2'b00, 0, 2'b11, 3);
    add("jr",   6'o00, 6'b001000, 3'b000, 0, 0, 1, 2'b00, 2'b10, 0, 2'b00, 0);
    add("addi", 6'b001000, 6'd0, 3'b000, 0, 1, 0, 2'b00, 2'b00, 1, 2'b00, 3);
    add("addiu",6'b001001, 6'd0, 3'b000, 0, 1, 0, 2'b00, 2'b00, 1, 2'b00, 3);
    add("slti", 6'b001010, 6'd0, 3'b110, 0, 1, 0, 2'b00, 2'b00, 1, 2'b00, 3);
    add("andi", 6'b001100, 6'd0, 3'b010, 0, 1, 0, 2'b00, 2'b00, 0, 2'b00, 3);
    add("ori",  6'b001101, 6'd0, 3'b011, 0, 1, 0, 2'b00, 2'b00, 0, 2'b00, 3);
    add("xori", 6'b001110, 6'd0, 3'b100, 0, 1, 0, 2'b00, 2'b00, 0, 2'b00, 3);
    add("lw",   6'b100011, 6'd0, 3'b000, 1, 1, 0, 2'b00, 2'b00, 1, 2'b00, 1);
    add("sw",   6'b101011, 6'd0, 3'b000, 0, 1, 0, 2'b00, 2'b00, 1, 2'b00, 2);
    add("beq",  6'b000100, 6'd0, 3'b001, 0, 0, 0, 2'b01, 2'b00, 1, 2'b00, 0);
    add("bne",  6'b000101, 6'd0, 3'b001, 0, 0, 0, 2'b10, 2'b00, 1, 2'b00, 0);
    add("j",    6'b000010, 6'd0, 3'b000, 0, 0, 0, 2'b00, 2'b01, 0, 2'b00, 0);
    add("jal",  6'b000011, 6'd0, 3'b000, 0, 0, 0, 2'b00, 2'b01, 0, 2'b00, 4);

    ill = '{name: "illegal", op: 6'd0, fn: 6'd0, alu: 3'd0, wbsrc: 1'b0, exrt: 1'b0,
            wsrc: 1'b0, br: 2'd0, jb: 2'd0, sext: 1'b0, sh: 2'd0, cls: 0};

    // Reset with ready high: every output must still be zero.
    mode = 2;
    repeat (2) step();
    cmp("reset_state", int'(W_state), 0);
    cmp("reset_outputs", all_outs(), 0);

    // add straight out of reset: 0,1,2,4,0 with first fetch on the first edge.
    rst = 1'b0;
    #1;
    cmp("first_fetch_ir", int'(W_ir_wea), 1);
    t = tbl[find("add")];
    sbq.push_back(mk_exp(t, 0));
    drive(t);
    step(); cmp("add_state_decode", int'(W_state), 1);
    step(); cmp("add_state_exec", int'(W_state), 2);
    op = 6'($urandom); fn = 6'($urandom);
    step(); cmp("add_state_wb", int'(W_state), 4);
    step(); cmp("add_state_fetch", int'(W_state), 0);

    // lw held in MEM for 3 not-ready cycles, then sw/beq/jal.
    mode = 3; low_lim = 3;
    issue(tbl[find("lw")], 4);
    issue(tbl[find("sw")], 4);
    mode = 2;
    issue(tbl[find("beq")], 0);
    issue(tbl[find("jal")], 0);

    // Randomized stream with random memory latency.
    mode = 0;
    for (int k = 0; k < 150; k++) begin
`ifndef MULTI_CYCLE_CTRL_TRAP_EN
      if ($urandom_range(0, 7) == 0) begin
        t = ill;
        n = 0;
        do begin t.op = 6'($urandom); t.fn = 6'($urandom); n++; end
        while (legal(t.op, t.fn) && n < 100);
        sbq.push_back(mk_exp(t, -1));
        op = t.op; fn = t.fn;
        run_to_fetch("illegal_rand");
        continue;
      end
`endif
      issue(tbl[$urandom_range(0, tbl.size() - 1)], -1);
    end

    // op 111111.
    mode = 2;
`ifdef MULTI_CYCLE_CTRL_TRAP_EN
    op = 6'b111111; fn = 6'd0;
    n = 0;
    while (W_state != 3'd5 && n < 20) begin step(); n++; end
    for (int k = 0; k < 4; k++) begin
      step();
      cmp("trap_state", int'(W_state), 5);
      cmp("trap_illegal", int'(W_illegal), 1);
      cmp("trap_pc_wea", int'(W_pc_wea), 0);
    end
    rst = 1'b1;
    step();
    cmp("trap_cleared", int'(W_illegal), 0);
    rst = 1'b0;
`else
    t = ill; t.op = 6'b111111;
    sbq.push_back(mk_exp(t, 0));
    op = t.op; fn = 6'd0;
    run_to_fetch("illegal_nop");
    issue(tbl[find("or")], 0);
`endif

    // Reset asserted in MEM while the store is still waiting on memory.
    mode = 3; low_lim = 1000;
    t = tbl[find("sw")];
    drive(t);
    n = 0;
    while (W_state != 3'd3 && n < 20) begin step(); n++; end
    step(); step();
    cmp("mem_wait_state", int'(W_state), 3);
    rst = 1'b1;
    #1;
    cmp("rst_mem_state", int'(W_state), 0);
    cmp("rst_mem_outputs", all_outs(), 0);
    cmp("rst_mem_no_store", int'(W_mem_wea), 0);
    step();
    rst = 1'b0;
    mode = 2;
    issue(tbl[find("sub")], 0);

    step(); step();
    cmp("scoreboard_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port W_instr_op  input  6  opcode from datapath decode.
REQ-004 SHALL have port W_instr_funct  input  6  R-type funct from datapath decode.
REQ-005 SHALL have port W_mem_ready  input  1  memory handshake; high = fetch/load/store completes this cycle.
REQ-006 SHALL have outputs W_regfile_wea(1), W_alu_sel(3), W_mem_wea(4), W_wb_regsrc_sel(1), W_ex_rt_sel(1), W_write_src_sel(1), W_branch(2), W_j_branch(2), W_imme_sign_extend(1), W_shift(2), W_jal_en(1), all driving the datapath control inputs of the same names.
REQ-007 SHALL have outputs W_pc_wea(1) PC load enable, W_ir_wea(1) instruction-register load, W_illegal(1) trap flag, W_state(3) current state for debug.

Function
REQ-008 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
REQ-009 FETCH: hold until W_mem_ready=1; that cycle assert W_ir_wea=1, go to DECODE.
REQ-010 DECODE: latch W_instr_op/W_instr_funct into internal registers; all later states decode only the latched copy; go to EXEC.
REQ-011 EXEC: beq/bne/j/jr -> assert W_pc_wea=1 for one cycle, go to FETCH; lw/sw -> MEM; jal and ALU ops -> WB.
REQ-012 MEM: hold until W_mem_ready=1; sw asserts W_mem_wea=4'b1111 only in that completing cycle, plus W_pc_wea=1, go to FETCH; lw goes to WB.
REQ-013 WB: assert W_regfile_wea=1 and W_pc_wea=1 for exactly one cycle, go to FETCH.
REQ-014 W_pc_wea SHALL pulse exactly once per legal instruction; W_regfile_wea and W_mem_wea SHALL be 0 outside WB and MEM respectively.
REQ-015 Decode: ALU codes ADD=000 SUB=001 AND=010 OR=011 XOR=100 NOR=101 SLT=110 SLTU=111.
REQ-016 R-type (op 000000): funct 100000/100001 ADD, 100010/100011 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT, 101011 SLTU; 000000/000010/000011 set W_shift 01/10/11; 001000 jr sets W_j_branch=10; W_write_src_sel=1.
REQ-017 I-type: addi 001000/addiu 001001/slti 001010 sign-extend; andi 001100/ori 001101/xori 001110 zero-extend; lw 100011/sw 101011 ADD, sign-extend, W_ex_rt_sel=1, W_write_src_sel=0; lw W_wb_regsrc_sel=1.
REQ-018 beq 000100 -> W_branch=01, bne 000101 -> 10, both ALU SUB, W_ex_rt_sel=0; j 000010/jal 000011 -> W_j_branch=01; jal asserts W_jal_en in WB.
REQ-019 Decode outputs SHALL be held stable from EXEC through end of instruction; in FETCH/DECODE all enables 0, fields 0.
REQ-020 Unlisted op/funct SHALL be illegal (see REQ-024).

Reset
REQ-021 rst=1 SHALL immediately force state FETCH, latched op/funct 0, W_illegal 0, all outputs 0, regardless of current state (including MEM mid-handshake).
REQ-022 First fetch SHALL begin on the first rising edge after rst deasserts.

Configuration
REQ-023 Macro MULTI_CYCLE_CTRL_TRAP_EN selects illegal-instruction handling.
REQ-024 Defined: illegal in EXEC -> TRAP, W_illegal=1, no enables, held until reset; undefined: illegal treated as NOP (W_pc_wea=1 in EXEC, to FETCH), W_illegal tied 0, TRAP unreachable.

Structure
REQ-025 Package ctrl_pkg SHALL hold state encoding, opcode/funct constants, ALU/shift/branch codes.
REQ-026 Combinational decode SHALL be sub-module ctrl_decode (latched op/funct -> control bundle + illegal); FSM in multi_cycle_ctrl.

Verification
REQ-027 add (op 000000, funct 100000), mem_ready=1 -> states 0,1,2,4,0; W_alu_sel=000, W_regfile_wea pulse in WB, one W_pc_wea.
REQ-028 lw (100011), mem_ready low 3 cycles in MEM -> MEM held 4 cycles, W_wb_regsrc_sel=1, regfile write one cycle after ready.
REQ-029 sw (101011) -> W_mem_wea=4'b1111 only in MEM ready cycle, no regfile write, return FETCH.
REQ-030 beq (000100) -> W_branch=01, W_alu_sel=001, W_pc_wea in EXEC, FETCH next; jal -> W_j_branch=01, W_jal_en=1 in WB.
REQ-031 op 111111 -> with TRAP_EN: state 5, W_illegal=1 held; without: NOP, next fetch proceeds.
REQ-032 rst asserted during MEM with mem_ready low -> outputs 0 same cycle, state FETCH, no W_mem_wea.
